// File: rtl/rob_recovery_ctrl.sv
// Branch-misprediction recovery sequencer: picks the oldest mispredict, flushes the ROB,
// then walks squashed entries youngest-to-oldest returning their pd_new to the free list.
module rob_recovery_ctrl #(
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W     = 5,
  parameter int PREG_W    = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_mispredict_a,
  input  logic [TAG_W-1:0]  br_tag_a,
  input  logic              br_mispredict_b,
  input  logic [TAG_W-1:0]  br_tag_b,
  input  logic [TAG_W-1:0]  rob_head,
  input  logic [TAG_W-1:0]  rob_wptr,
  input  logic [PREG_W-1:0] walk_pd_new,
  output logic              rob_flush,
  output logic [TAG_W-1:0]  rob_flush_tag,
  output logic [TAG_W-1:0]  walk_idx,
  output logic              free_valid,
  output logic [PREG_W-1:0] free_preg,
  output logic              stall_dispatch,
  output logic              busy,
  output logic              recovery_done
);

  typedef enum logic [1:0] {IDLE, FLUSH, WALK, DONE} state_t;

  localparam logic [TAG_W-1:0] LAST    = TAG_W'(ROB_DEPTH - 1);
  localparam logic [TAG_W:0]   DEPTH_X = (TAG_W + 1)'(ROB_DEPTH);

  state_t           state, state_nxt;
  logic [TAG_W-1:0] target, target_nxt;
  logic [TAG_W-1:0] walk_ptr, walk_ptr_nxt;

  logic             req_any, pick_b, older;
  logic [TAG_W-1:0] age_a, age_b, age_sel, age_tgt, sel_tag;

  function automatic logic [TAG_W-1:0] ptr_dec(input logic [TAG_W-1:0] p);
    return (p == '0) ? LAST : p - 1'b1;
  endfunction

  function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Distance from the current head; one extra bit avoids underflow before the modulo.
  function automatic logic [TAG_W-1:0] age_of(input logic [TAG_W-1:0] t,
                                              input logic [TAG_W-1:0] h);
    logic [TAG_W:0] s;
    s = {1'b0, t} + DEPTH_X - {1'b0, h};
    if (s >= DEPTH_X) s = s - DEPTH_X;
    return s[TAG_W-1:0];
  endfunction

  always_comb begin
    age_a   = age_of(br_tag_a, rob_head);
    age_b   = age_of(br_tag_b, rob_head);
    age_tgt = age_of(target, rob_head);
    req_any = br_mispredict_a | br_mispredict_b;
    pick_b  = br_mispredict_b && (!br_mispredict_a || (age_b < age_a));
    sel_tag = pick_b ? br_tag_b : br_tag_a;
    age_sel = pick_b ? age_b : age_a;
    older   = req_any && (age_sel < age_tgt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      target   <= '0;
      walk_ptr <= '0;
    end else begin
      state    <= state_nxt;
      target   <= target_nxt;
      walk_ptr <= walk_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    target_nxt     = target;
    walk_ptr_nxt   = walk_ptr;
    rob_flush      = 1'b0;
    rob_flush_tag  = '0;
    walk_idx       = '0;
    free_valid     = 1'b0;
    free_preg      = '0;
    recovery_done  = 1'b0;
    busy           = (state != IDLE);
    // Dispatch must stop the same cycle a mispredict shows up, before the FSM reacts.
    stall_dispatch = busy || (req_any && reset);
    case (state)
      IDLE, DONE: begin
        recovery_done = (state == DONE);
        if (req_any) begin
          state_nxt    = FLUSH;
          target_nxt   = sel_tag;
          walk_ptr_nxt = ptr_dec(rob_wptr);
        end else begin
          state_nxt = IDLE;
        end
      end
      FLUSH: begin
        rob_flush     = 1'b1;
        rob_flush_tag = target;
        if (older) begin
          target_nxt = sel_tag;
          state_nxt  = FLUSH;
        end else if (walk_ptr != target) begin
          state_nxt = WALK;
        end else begin
          state_nxt = DONE;
        end
      end
      WALK: begin
        walk_idx     = walk_ptr;
        free_valid   = 1'b1;
        free_preg    = walk_pd_new;
        walk_ptr_nxt = ptr_dec(walk_ptr);
        // An older branch retargets the walk; the pointer keeps descending from where it is.
        if (older) begin
          target_nxt = sel_tag;
          state_nxt  = FLUSH;
        end else if (walk_ptr == ptr_inc(target)) begin
          state_nxt = DONE;
        end else begin
          state_nxt = WALK;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/rob_recovery_ctrl.md
Name: rob_recovery_ctrl

Overview:
- Sequences branch-misprediction recovery around the ROB.
- Arbitrates up to two mispredict reports per cycle, selects the oldest relative to ROB head and issues a one-cycle flush to the ROB.
- Then walks squashed entries youngest-to-oldest, returning each pd_new to the free list one per cycle, and stalls dispatch until done.

Parameters:
- ROB_DEPTH, 16, number of ROB entries; all index arithmetic is mod ROB_DEPTH.
- TAG_W, 5, width of ROB tags/pointers.
- PREG_W, 7, physical register tag width.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
br_mispredict_a  in  1  mispredict report, branch unit A
br_tag_a  in  TAG_W  ROB tag of branch A
br_mispredict_b  in  1  mispredict report, branch unit B
br_tag_b  in  TAG_W  ROB tag of branch B
rob_head  in  TAG_W  current ROB head index
rob_wptr  in  TAG_W  current ROB write pointer (next free entry)
walk_pd_new  in  PREG_W  ROB read data: pd_new of entry walk_idx (valid regardless of entry valid bit)
rob_flush  out  1  one-cycle flush pulse to ROB
rob_flush_tag  out  TAG_W  branch tag for flush (ROB keeps tag, squashes younger)
walk_idx  out  TAG_W  ROB entry being read during walk
free_valid  out  1  free_preg valid this cycle
free_preg  out  PREG_W  physical register returned to free list
stall_dispatch  out  1  block dispatch while recovering
busy  out  1  state != IDLE
recovery_done  out  1  one-cycle pulse when recovery completes

Behaviour:
- Reset (reset=0, async): state=IDLE; target, walk pointer and all outputs 0. Reset mid-walk abandons recovery with no further frees.
- Age(t) = (t - rob_head) mod ROB_DEPTH; smaller is older.
- Arbitration: if both requests are valid, pick the smaller age; equal tags pick A. Callers guarantee reported tags lie in [head, wptr).
- States: IDLE, FLUSH, WALK, DONE.
- IDLE:
  - Request sampled at posedge N → latch target=selected tag and walk_ptr=(rob_wptr-1) mod ROB_DEPTH.
  - Enter FLUSH at N+1.
- FLUSH (1 cycle): rob_flush=1, rob_flush_tag=target.
  - Next state is WALK if walk_ptr != target (younger entries exist), else DONE.
- WALK, one entry per cycle:
  - walk_idx=walk_ptr; free_valid=1; free_preg=walk_pd_new (combinational pass-through).
  - walk_ptr decrements mod ROB_DEPTH, wrapping 0 → ROB_DEPTH-1.
  - When the entry just freed is (target+1) mod ROB_DEPTH, next state is DONE.
  - Number of frees = (latched wptr - target - 1) mod ROB_DEPTH.
- DONE (1 cycle): recovery_done=1, then IDLE. A request arriving in DONE is handled as in IDLE (next state FLUSH).
- New request while in FLUSH or WALK:
  - If its age < Age(target): target=new tag; next state FLUSH (re-flush at older tag). walk_ptr is preserved and the walk continues downward to the new target.
  - Otherwise (younger or equal): ignored, since it is already squashed.
  - In WALK, the free for the current cycle still completes.
- stall_dispatch = busy, and is also asserted combinationally in the cycle a request is presented in IDLE.
- rob_head may advance (retirement of older entries) during recovery. Ages are always computed against the current rob_head.
- No output other than recovery_done, rob_flush and free_valid pulses; those outputs are 0 outside their states.

Test Plan:
- Single: head=0, wptr=7, A reports tag 4 → FLUSH pulse with tag 4 next cycle; WALK frees entries 6 then 5 (2 cycles); recovery_done; stall_dispatch high for 5 cycles total.
- Dual arbitration: head=0, wptr=10, A=tag 6, B=tag 3 same cycle → rob_flush_tag=3; frees entries 9..4 (6 frees). Repeat with head=5, A=2, B=7 → tag 7 chosen (age 2 vs 13).
- Wrap: head=12, wptr=3, tag 14 → frees entries 2, 1, 0, 15 in that order; walk_idx wraps 0 → 15.
- Older during walk: head=0, wptr=12, tag 8. After first free (entry 11), B reports tag 5 → second rob_flush with tag 5, walk resumes at 10 and stops after 6; total frees 11..6. A younger report (tag 9) at the same point is ignored.
- No younger entries: head=0, wptr=5, tag 4 → FLUSH then DONE, zero free_valid pulses.
- Async reset asserted mid-WALK → all outputs 0 immediately; after release, state is IDLE and a new tag-2 request recovers normally.
